// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one writeback/completion bus among FU_COUNT functional
// units. Each FU drops its finished result into a one-entry holding slot; a
// round-robin arbiter moves one slot per cycle into a registered output stage
// that drives the PRF write port, ROB completion and the wakeup broadcast.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   flush                 synchronous squash of every held and output result
//   fu_in_*               per-FU result payload and its valid
//   fu_ready              per-FU slot accepts a result this cycle
//   wb_ready              consumer accepts the output stage this cycle
//   wb_*                  output stage: valid, inst id, PRNs, data,
//                         per-operand write enables (qualified by wb_valid)
//   wb_src                FU index whose result sits in the output stage
//   rr_ptr                round-robin search start (debug visibility)
//
// Handshake: every interface moves a result on a rising edge where its
// valid and ready are both 1. A producer keeps valid and payload stable until
// that edge; ready may depend combinationally on downstream ready (fu_ready
// follows wb_ready) so a slot can refill on the same edge it drains.
module wb_arbiter #(
  parameter int FU_COUNT     = 4,
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  localparam int SRC_W       = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [FU_COUNT-1:0]     fu_in_valid,
  input  logic [INST_ID_BITS-1:0] fu_in_inst_id    [FU_COUNT],
  input  logic [PRN_BITS-1:0]     fu_in_prn        [FU_COUNT][MAX_OPERANDS],
  input  logic [63:0]             fu_in_data       [FU_COUNT][MAX_OPERANDS],
  input  logic [MAX_OPERANDS-1:0] fu_in_data_valid [FU_COUNT],
  output logic [FU_COUNT-1:0]     fu_ready,
  input  logic                    wb_ready,
  output logic                    wb_valid,
  output logic [INST_ID_BITS-1:0] wb_inst_id,
  output logic [PRN_BITS-1:0]     wb_prn  [MAX_OPERANDS],
  output logic [63:0]             wb_data [MAX_OPERANDS],
  output logic [MAX_OPERANDS-1:0] wb_data_valid,
  output logic [SRC_W-1:0]        wb_src,
  output logic [SRC_W-1:0]        rr_ptr
);

  // Holding slots
  logic [FU_COUNT-1:0]     slot_valid;
  logic [INST_ID_BITS-1:0] slot_inst_id [FU_COUNT];
  logic [PRN_BITS-1:0]     slot_prn     [FU_COUNT][MAX_OPERANDS];
  logic [63:0]             slot_data    [FU_COUNT][MAX_OPERANDS];
  logic [MAX_OPERANDS-1:0] slot_dv      [FU_COUNT];

  // Output stage write enables before qualification by wb_valid
  logic [MAX_OPERANDS-1:0] wb_dv_q;

  logic                out_free;
  logic                grant_any;
  logic [SRC_W-1:0]    grant_idx;
  logic [FU_COUNT-1:0] grant;
  logic [SRC_W-1:0]    scan_idx;
  logic [SRC_W-1:0]    rr_next;

  assign out_free = !wb_valid || wb_ready;

  // Round-robin search starting at rr_ptr; first valid slot wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (out_free) begin
      for (int o = 0; o < FU_COUNT; o++) begin
        scan_idx = SRC_W'((int'(rr_ptr) + o) % FU_COUNT);
        if (!grant_any && slot_valid[scan_idx]) begin
          grant_any         = 1'b1;
          grant_idx         = scan_idx;
          grant[scan_idx]   = 1'b1;
        end
      end
    end
  end

  assign rr_next = (grant_idx == SRC_W'(FU_COUNT - 1)) ? '0 : grant_idx + SRC_W'(1);

  // A granted slot is emptying this edge, so it may take a new result at once.
  // rst gates ready so FUs see no acceptance while the block is in reset.
  always_comb begin
    fu_ready = '0;
    if (rst && !flush) fu_ready = ~slot_valid | grant;
  end

  assign wb_data_valid = wb_valid ? wb_dv_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_valid <= '0;
      wb_valid   <= 1'b0;
      wb_inst_id <= '0;
      wb_dv_q    <= '0;
      wb_src     <= '0;
      rr_ptr     <= '0;
      for (int i = 0; i < FU_COUNT; i++) begin
        slot_inst_id[i] <= '0;
        slot_dv[i]      <= '0;
        for (int j = 0; j < MAX_OPERANDS; j++) begin
          slot_prn[i][j]  <= '0;
          slot_data[i][j] <= '0;
        end
      end
      for (int j = 0; j < MAX_OPERANDS; j++) begin
        wb_prn[j]  <= '0;
        wb_data[j] <= '0;
      end
    end else if (flush) begin
      // Squash everything in flight; the arbitration pointer is kept.
      slot_valid <= '0;
      wb_valid   <= 1'b0;
    end else begin
      for (int i = 0; i < FU_COUNT; i++) begin
        if (fu_in_valid[i] && fu_ready[i]) begin
          // Capture wins over drain: a granted slot refilled this edge stays full.
          slot_valid[i]   <= 1'b1;
          slot_inst_id[i] <= fu_in_inst_id[i];
          slot_dv[i]      <= fu_in_data_valid[i];
          for (int j = 0; j < MAX_OPERANDS; j++) begin
            slot_prn[i][j]  <= fu_in_prn[i][j];
            slot_data[i][j] <= fu_in_data[i][j];
          end
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (grant_any) begin
        wb_valid   <= 1'b1;
        wb_src     <= grant_idx;
        wb_inst_id <= slot_inst_id[grant_idx];
        wb_dv_q    <= slot_dv[grant_idx];
        for (int j = 0; j < MAX_OPERANDS; j++) begin
          wb_prn[j]  <= slot_prn[grant_idx][j];
          wb_data[j] <= slot_data[grant_idx][j];
        end
        rr_ptr <= rr_next;
      end else if (out_free) begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios followed by random traffic.
// A transaction-level reference model (slot occupancy, pointer, expected
// output queue) advances on each rising edge; a monitor on the falling edge
// compares the DUT against it.
module tb_wb_arbiter;

  typedef struct packed {
    logic [1:0]       src;
    logic [5:0]       id;
    logic [2:0][5:0]  prn;
    logic [2:0][63:0] data;
    logic [2:0]       dv;
  } item_t;

  localparam int W = $bits(item_t);

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic        flush;
  logic [3:0]  fu_in_valid;
  logic [5:0]  fu_in_inst_id    [4];
  logic [5:0]  fu_in_prn        [4][3];
  logic [63:0] fu_in_data       [4][3];
  logic [2:0]  fu_in_data_valid [4];
  logic [3:0]  fu_ready;
  logic        wb_ready;
  logic        wb_valid;
  logic [5:0]  wb_inst_id;
  logic [5:0]  wb_prn  [3];
  logic [63:0] wb_data [3];
  logic [2:0]  wb_data_valid;
  logic [1:0]  wb_src;
  logic [1:0]  rr_ptr;

  wb_arbiter #(
    .FU_COUNT(4), .INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_in_valid(fu_in_valid), .fu_in_inst_id(fu_in_inst_id),
    .fu_in_prn(fu_in_prn), .fu_in_data(fu_in_data),
    .fu_in_data_valid(fu_in_data_valid), .fu_ready(fu_ready),
    .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_inst_id(wb_inst_id),
    .wb_prn(wb_prn), .wb_data(wb_data), .wb_data_valid(wb_data_valid),
    .wb_src(wb_src), .rr_ptr(rr_ptr)
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];     // result expected in the output stage
  item_t m_slot [4];
  bit    m_full [4];
  int    m_ptr = 0;
  int    remaining [4];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t cur_in(int i);
    item_t it;
    it.src = 2'(i);
    it.id  = fu_in_inst_id[i];
    it.dv  = fu_in_data_valid[i];
    for (int j = 0; j < 3; j++) begin
      it.prn[j]  = fu_in_prn[i][j];
      it.data[j] = fu_in_data[i][j];
    end
    return it;
  endfunction

  function automatic item_t dut_item();
    item_t it;
    it.src = wb_src;
    it.id  = wb_inst_id;
    it.dv  = wb_data_valid;
    for (int j = 0; j < 3; j++) begin
      it.prn[j]  = wb_prn[j];
      it.data[j] = wb_data[j];
    end
    return it;
  endfunction

  // Which FU the spec says is granted now (-1 for none).
  function automatic int model_grant();
    if (exp_q.size() != 0 && !wb_ready) return -1;
    for (int o = 0; o < 4; o++) begin
      if (m_full[(m_ptr + o) % 4]) return (m_ptr + o) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    logic [3:0] r;
    int g;
    g = model_grant();
    for (int i = 0; i < 4; i++) r[i] = rst && !flush && (!m_full[i] || g == i);
    return r;
  endfunction

  // ---------------- reference model: advances on each edge ----------------
  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        for (int i = 0; i < 4; i++) m_full[i] = 0;
        m_ptr = 0;
        exp_q.delete();
      end else begin
        int g;
        logic [3:0] rdy;
        g   = model_grant();
        rdy = model_ready();
        if (flush) begin
          for (int i = 0; i < 4; i++) m_full[i] = 0;
          exp_q.delete();
        end else begin
          if (g >= 0) begin
            exp_q.push_back(m_slot[g]);
            m_full[g] = 0;
            m_ptr = (g + 1) % 4;
          end
          for (int i = 0; i < 4; i++) begin
            if (fu_in_valid[i] && rdy[i]) begin
              m_slot[i] = cur_in(i);
              m_full[i] = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("reset_wb_valid", 64'(wb_valid), 64'd0);
        chk("reset_fu_ready", 64'(fu_ready), 64'd0);
        chk("reset_wb_dv", 64'(wb_data_valid), 64'd0);
        chk("reset_wb_src", 64'(wb_src), 64'd0);
      end else begin
        chk("fu_ready", 64'(fu_ready), 64'(model_ready()));
        chk("rr_ptr", 64'(rr_ptr), 64'(m_ptr));
        chk("wb_valid", 64'(wb_valid), 64'(exp_q.size() != 0));
        if (!wb_valid) chk("idle_wb_dv", 64'(wb_data_valid), 64'd0);
        if (exp_q.size() != 0) begin
          if (wb_valid) begin
            tests_run++;
            if (W'(dut_item()) !== exp_q[0]) begin
              tests_failed++;
              $display("FAIL wb_payload: got %h expected %h at %0t", W'(dut_item()), exp_q[0], $time);
            end
          end
          if (wb_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic load_rand(int i);
    fu_in_valid[i]      = 1'b1;
    fu_in_inst_id[i]    = 6'($urandom_range(0, 63));
    fu_in_data_valid[i] = 3'($urandom_range(0, 7));
    for (int j = 0; j < 3; j++) begin
      fu_in_prn[i][j]  = 6'($urandom_range(0, 63));
      fu_in_data[i][j] = {$urandom, $urandom};
    end
  endtask

  // One clock: FUs drop accepted results and present the next one if queued.
  task automatic tick();
    logic [3:0] acc;
    @(negedge clk);
    acc = fu_in_valid & fu_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) fu_in_valid[i] = 1'b0;
      if (!fu_in_valid[i] && remaining[i] > 0) begin
        load_rand(i);
        remaining[i]--;
      end
    end
  endtask

  initial begin
    int saved_ptr;
    rst = 1'b0;
    flush = 1'b0;
    wb_ready = 1'b1;
    fu_in_valid = 4'hF;
    for (int i = 0; i < 4; i++) begin
      remaining[i] = 0;
      fu_in_inst_id[i] = '0;
      fu_in_data_valid[i] = '0;
      for (int j = 0; j < 3; j++) begin
        fu_in_prn[i][j] = '0;
        fu_in_data[i][j] = '0;
      end
    end

    // Reset held with every FU requesting
    repeat (3) tick();
    fu_in_valid = 4'h0;
    tick();
    rst = 1'b1;
    #1;
    chk("post_reset_fu_ready", 64'(fu_ready), 64'hF);
    chk("post_reset_rr_ptr", 64'(rr_ptr), 64'd0);
    tick();

    // Single result from FU2, two-cycle latency
    fu_in_valid[2] = 1'b1;
    fu_in_inst_id[2] = 6'd5;
    fu_in_prn[2][0] = 6'd7; fu_in_prn[2][1] = 6'd0; fu_in_prn[2][2] = 6'd0;
    fu_in_data[2][0] = 64'hAB; fu_in_data[2][1] = 64'd0; fu_in_data[2][2] = 64'd0;
    fu_in_data_valid[2] = 3'b001;
    tick();
    tick();
    chk("single_wb_valid", 64'(wb_valid), 64'd1);
    chk("single_wb_src", 64'(wb_src), 64'd2);
    chk("single_inst_id", 64'(wb_inst_id), 64'd5);
    chk("single_dv", 64'(wb_data_valid), 64'b001);
    chk("single_prn0", 64'(wb_prn[0]), 64'd7);
    chk("single_data0", wb_data[0], 64'hAB);

    // FU2 streams every cycle
    remaining[2] = 10;
    repeat (14) tick();

    // Bring rr_ptr to 0 via a lone FU3 result, then all four at once
    remaining[3] = 1;
    repeat (4) tick();
    chk("rr_ptr_before_all", 64'(rr_ptr), 64'd0);
    for (int i = 0; i < 4; i++) remaining[i] = 1;
    repeat (8) tick();
    remaining[0] = 1;
    remaining[3] = 1;
    repeat (6) tick();

    // Backpressure with FU0 and FU1 pending
    wb_ready = 1'b0;
    remaining[0] = 2;
    remaining[1] = 1;
    repeat (5) tick();
    chk("bp_fu_ready01", 64'(fu_ready[1:0]), 64'd0);
    wb_ready = 1'b1;
    repeat (6) tick();

    // Flush with slots full and the output stage occupied
    wb_ready = 1'b0;
    remaining[0] = 2;
    remaining[1] = 1;
    remaining[2] = 1;
    repeat (4) tick();
    saved_ptr = m_ptr;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_fu_ready", 64'(fu_ready), 64'hF);
    chk("flush_rr_ptr", 64'(rr_ptr), 64'(saved_ptr));
    wb_ready = 1'b1;
    repeat (6) tick();

    // Starvation: FU0/FU1 continuous, FU3 once
    remaining[0] = 20;
    remaining[1] = 20;
    remaining[3] = 1;
    repeat (30) tick();

    // Random traffic with backpressure and occasional flush
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++)
        if (remaining[i] == 0 && $urandom_range(0, 3) == 0) remaining[i] = 1;
      wb_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 63) == 0);
      tick();
    end

    // Drain
    flush = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) remaining[i] = 0;
    repeat (10) tick();
    chk("drain_wb_valid", 64'(wb_valid), 64'd0);
    chk("drain_fu_ready", 64'(fu_ready), 64'hF);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Shares the single writeback/completion bus among the FU_COUNT functional units. Each FU deposits its finished result (inst_id, destination PRNs, data) into a one-entry holding slot. A round-robin arbiter moves one slot per cycle into a registered output stage. That stage drives the PRF write port, the ROB completion input and the set_prn/set_prn_ready wakeup broadcast seen by every issue queue.

## Interface
- FU_COUNT, 4, number of functional units arbitrated
- INST_ID_BITS, 6, ROB instruction id width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, result operand slots per instruction
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- flush  input  1  synchronous squash of all in-flight results
- fu_in_valid[FU_COUNT]  input  1  FU i presents a completed result
- fu_in_inst_id[FU_COUNT]  input  INST_ID_BITS  instruction id of FU i result
- fu_in_prn[FU_COUNT][MAX_OPERANDS]  input  PRN_BITS  destination PRNs
- fu_in_data[FU_COUNT][MAX_OPERANDS]  input  64  result data
- fu_in_data_valid[FU_COUNT][MAX_OPERANDS]  input  1  operand j of result is written
- fu_ready[FU_COUNT]  output  1  slot i accepts a result this cycle
- wb_ready  input  1  consumer (PRF/ROB) accepts the output stage this cycle
- wb_valid  output  1  output stage holds a result
- wb_inst_id  output  INST_ID_BITS  winning instruction id
- wb_prn[MAX_OPERANDS]  output  PRN_BITS  winning destination PRNs
- wb_data[MAX_OPERANDS]  output  64  winning data
- wb_data_valid[MAX_OPERANDS]  output  1  per-operand write enable, already qualified by wb_valid
- wb_src[$clog2(FU_COUNT)]  output  —  index of FU whose result is in the output stage

## Operation
- State: slot_valid[i] plus the captured payload per FU, the output register and its valid bit, and rr_ptr (clog2(FU_COUNT) bits).
- Capture: at an edge where fu_in_valid[i] && fu_ready[i], slot i loads the payload and sets slot_valid[i]. fu_in_valid without fu_ready is ignored. The FU holds its result until it sees ready.
- out_free = !wb_valid || wb_ready.
- Arbitration (combinational): among slot_valid, grant the first index k found searching rr_ptr, rr_ptr+1, … mod FU_COUNT. Grant happens only when out_free.
- Transfer: at the edge, slot k's payload goes to the output register, wb_valid=1, wb_src=k, slot_valid[k] clears unless reloaded the same edge, and rr_ptr ← (k+1) mod FU_COUNT.
- No grant while out_free: wb_valid clears at the edge. No grant means rr_ptr holds.
- fu_ready[i] = !flush && (!slot_valid[i] || grant[i]). This path from wb_ready to fu_ready is combinational and intentional, so a slot refills on the edge it drains.
- wb_data_valid[j] = wb_valid && stored data_valid[j]. When wb_valid=0, all wb_* data fields are don't-care except wb_data_valid, which is 0.
- Fairness: a valid slot is granted within FU_COUNT transfers.
- flush: at the edge, all slot_valid and wb_valid clear. Captures and grants in that cycle are discarded. rr_ptr is unchanged. fu_ready is 0 throughout the flush cycle.

## Timing
- Reset (rst=0, async): slot_valid=0, wb_valid=0, wb_data_valid=0, wb_src=0, rr_ptr=0, wb_inst_id/wb_prn/wb_data=0. fu_ready=1 for all FUs once rst=1, given flush=0.
- Latency: with an idle arbiter, fu_in_valid accepted at edge E0 gives wb_valid=1 after E1, two cycles.
- Throughput: one result per cycle in total. A single FU sustains one result per cycle when it is the only requester and wb_ready=1.
- Backpressure: wb_ready=0 with wb_valid=1 holds every wb_* output stable. Slots stay full and fu_ready drops for full slots.
- Simultaneous events:
  - Capture and grant on the same slot at one edge: the new payload lands in the slot and the old payload goes to the output.
  - All FUs valid at once: served in order rr_ptr, rr_ptr+1, ….
- Reset mid-transfer: all results are lost and there is no partial output.

## Test plan
- Reset: hold rst=0, drive fu_in_valid all 1 → wb_valid=0 and fu_ready=0 while in reset (flush irrelevant); after release rr_ptr=0 and fu_ready all 1.
- Single FU: FU2 sends inst_id=5, prn={7,0,0}, data={0xAB,-,-}, dv={1,0,0} at E0 → after E1 wb_valid=1, wb_src=2, wb_inst_id=5, wb_data_valid={1,0,0}; streaming FU2 every cycle with wb_ready=1 gives no bubbles.
- Round-robin: all 4 FUs valid at E0 with wb_ready=1 → wb_src sequence 0,1,2,3 on consecutive cycles. Then refill FUs 0 and 3 only, with rr_ptr=0 → order 0,3.
- Backpressure: wb_ready=0 for 5 cycles with FUs 0 and 1 pending → wb_* stable, fu_ready[0..1]=0. Release → remaining results drain with none lost or duplicated.
- Flush: 3 slots full and wb_valid=1, pulse flush for 1 cycle → next cycle wb_valid=0, all fu_ready=1, rr_ptr unchanged, no stale result appears.
- Starvation: FU0 and FU1 continuously valid, FU3 valid once → FU3 is granted within 4 transfers.
